// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO between the UART core and its register block.
// Show-ahead read data, registered occupancy/flags, sticky overflow/underflow errors.
module uart_sync_fifo #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned AFULL_TH = 12
) (
   input  logic              glb_clk,
   input  logic              glb_rstn,
   input  logic              FIFO_clr,
   input  logic              FIFO_w_en,
   input  logic [DATA_W-1:0] FIFO_w_data,
   input  logic              FIFO_r_en,
   output logic [DATA_W-1:0] FIFO_r_data,
   output logic              FIFO_ctrl_full,
   output logic              FIFO_ctrl_empty,
   output logic              FIFO_ctrl_afull,
   output logic [ADDR_W:0]   FIFO_count,
   output logic              FIFO_overflow,
   output logic              FIFO_underflow
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned PTR_W = ADDR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              wr_acc_c;
   logic              rd_acc_c;
   logic [PTR_W-1:0]  count_nxt_c;

   // Flush wins over both requests; accept decisions use pre-edge flags.
   assign wr_acc_c = FIFO_w_en && !FIFO_ctrl_full  && !FIFO_clr;
   assign rd_acc_c = FIFO_r_en && !FIFO_ctrl_empty && !FIFO_clr;

   assign FIFO_r_data = mem[rd_ptr[ADDR_W-1:0]];

   always_comb begin
      count_nxt_c = FIFO_count;
      if (wr_acc_c && !rd_acc_c) begin
         count_nxt_c = FIFO_count + PTR_W'(1);
      end else if (rd_acc_c && !wr_acc_c) begin
         count_nxt_c = FIFO_count - PTR_W'(1);
      end
   end

   // Storage array is intentionally left unreset.
   always_ff @(posedge glb_clk) begin
      if (wr_acc_c) begin
         mem[wr_ptr[ADDR_W-1:0]] <= FIFO_w_data;
      end
   end

   always_ff @(posedge glb_clk or negedge glb_rstn) begin
      if (!glb_rstn) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         FIFO_count      <= '0;
         FIFO_ctrl_empty <= 1'b1;
         FIFO_ctrl_full  <= 1'b0;
         FIFO_ctrl_afull <= 1'b0;
         FIFO_overflow   <= 1'b0;
         FIFO_underflow  <= 1'b0;
      end else if (FIFO_clr) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         FIFO_count      <= '0;
         FIFO_ctrl_empty <= 1'b1;
         FIFO_ctrl_full  <= 1'b0;
         FIFO_ctrl_afull <= 1'b0;
         FIFO_overflow   <= 1'b0;
         FIFO_underflow  <= 1'b0;
      end else begin
         if (wr_acc_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (rd_acc_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         FIFO_count      <= count_nxt_c;
         FIFO_ctrl_empty <= (count_nxt_c == '0);
         FIFO_ctrl_full  <= (count_nxt_c == PTR_W'(DEPTH));
         FIFO_ctrl_afull <= (count_nxt_c >= PTR_W'(AFULL_TH));
         FIFO_overflow   <= FIFO_overflow  | (FIFO_w_en && FIFO_ctrl_full);
         FIFO_underflow  <= FIFO_underflow | (FIFO_r_en && FIFO_ctrl_empty);
      end
   end

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Directed self-checking bench for uart_sync_fifo: vector table plus
// hand-written sequences for fill/drain, simultaneous access, wrap, flush and reset.
module tb_uart_sync_fifo;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 4;

   logic              glb_clk;
   logic              glb_rstn;
   logic              FIFO_clr;
   logic              FIFO_w_en;
   logic [DATA_W-1:0] FIFO_w_data;
   logic              FIFO_r_en;
   logic [DATA_W-1:0] FIFO_r_data;
   logic              FIFO_ctrl_full;
   logic              FIFO_ctrl_empty;
   logic              FIFO_ctrl_afull;
   logic [ADDR_W:0]   FIFO_count;
   logic              FIFO_overflow;
   logic              FIFO_underflow;

   int n_checks;
   int n_errors;

   uart_sync_fifo #(.DATA_W(8), .ADDR_W(4), .AFULL_TH(12)) dut (
      .glb_clk        (glb_clk),
      .glb_rstn       (glb_rstn),
      .FIFO_clr       (FIFO_clr),
      .FIFO_w_en      (FIFO_w_en),
      .FIFO_w_data    (FIFO_w_data),
      .FIFO_r_en      (FIFO_r_en),
      .FIFO_r_data    (FIFO_r_data),
      .FIFO_ctrl_full (FIFO_ctrl_full),
      .FIFO_ctrl_empty(FIFO_ctrl_empty),
      .FIFO_ctrl_afull(FIFO_ctrl_afull),
      .FIFO_count     (FIFO_count),
      .FIFO_overflow  (FIFO_overflow),
      .FIFO_underflow (FIFO_underflow)
   );

   initial glb_clk = 1'b0;
   always #5 glb_clk = ~glb_clk;

   typedef struct {
      logic       clr;
      logic       w_en;
      logic [7:0] w_data;
      logic       r_en;
      int         cnt;
      logic       empty;
      logic       full;
      logic       afull;
      logic       ovf;
      logic       udf;
      logic       chk_data;
      logic [7:0] data;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_state(input string tag, input int cnt, input int empty, input int full,
                            input int afull, input int ovf, input int udf);
      chk({tag, " count"},     int'(FIFO_count),      cnt);
      chk({tag, " empty"},     int'(FIFO_ctrl_empty), empty);
      chk({tag, " full"},      int'(FIFO_ctrl_full),  full);
      chk({tag, " afull"},     int'(FIFO_ctrl_afull), afull);
      chk({tag, " overflow"},  int'(FIFO_overflow),   ovf);
      chk({tag, " underflow"}, int'(FIFO_underflow),  udf);
   endtask

   // Drive one cycle of requests, then sample 1ns after the edge.
   task automatic cyc(input logic clr, input logic w, input logic [7:0] wd, input logic r);
      FIFO_clr    = clr;
      FIFO_w_en   = w;
      FIFO_w_data = wd;
      FIFO_r_en   = r;
      @(posedge glb_clk);
      #1;
      FIFO_clr  = 1'b0;
      FIFO_w_en = 1'b0;
      FIFO_r_en = 1'b0;
   endtask

   initial begin
      logic [7:0] q [$];
      logic [7:0] v;
      int         c;
      n_checks = 0;
      n_errors = 0;

      //           clr  w    wdata  r   cnt e   f   a   ovf udf cd  data
      for (int i = 0; i < 5; i++)
         tbl[i] = '{1'b0,1'b0,8'h00,1'b0, 0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};
      tbl[5] = '{1'b0,1'b1,8'h55,1'b0, 1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'h55};
      tbl[6] = '{1'b0,1'b0,8'h00,1'b1, 0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};
      tbl[7] = '{1'b0,1'b0,8'h00,1'b1, 0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,8'h00};
      tbl[8] = '{1'b1,1'b1,8'h99,1'b1, 0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};

      glb_rstn    = 1'b0;
      FIFO_clr    = 1'b0;
      FIFO_w_en   = 1'b0;
      FIFO_w_data = '0;
      FIFO_r_en   = 1'b0;
      repeat (2) @(posedge glb_clk);
      #1;
      chk_state("reset", 0, 1, 0, 0, 0, 0);
      glb_rstn = 1'b1;

      for (int i = 0; i < 9; i++) begin
         cyc(tbl[i].clr, tbl[i].w_en, tbl[i].w_data, tbl[i].r_en);
         chk_state($sformatf("vec%0d", i), tbl[i].cnt, int'(tbl[i].empty), int'(tbl[i].full),
                   int'(tbl[i].afull), int'(tbl[i].ovf), int'(tbl[i].udf));
         if (tbl[i].chk_data)
            chk($sformatf("vec%0d r_data", i), int'(FIFO_r_data), int'(tbl[i].data));
      end

      // Fill to full, watching afull and full thresholds.
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b1, 8'(i), 1'b0);
         chk_state($sformatf("fill%0d", i), i + 1, 0, int'(i == 15), int'(i + 1 >= 12), 0, 0);
      end
      cyc(1'b0, 1'b1, 8'hAA, 1'b0);
      chk_state("overflow write", 16, 0, 1, 1, 1, 0);

      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain%0d r_data", i), int'(FIFO_r_data), i);
         cyc(1'b0, 1'b0, 8'h00, 1'b1);
         chk_state($sformatf("drain%0d", i), 15 - i, int'(i == 15), 0, int'(15 - i >= 12), 1, 0);
      end

      // Simultaneous write+read while full: read wins, write dropped.
      for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'(32 + i), 1'b0);
      chk("refill full", int'(FIFO_ctrl_full), 1);
      cyc(1'b0, 1'b1, 8'h77, 1'b1);
      chk_state("full w+r", 15, 0, 0, 1, 1, 0);
      for (int i = 1; i < 16; i++) begin
         chk($sformatf("post-full drain%0d r_data", i), int'(FIFO_r_data), 32 + i);
         cyc(1'b0, 1'b0, 8'h00, 1'b1);
      end
      chk_state("post-full drained", 0, 1, 0, 0, 1, 0);

      // Simultaneous write+read while empty: write wins, read flagged.
      cyc(1'b0, 1'b1, 8'h33, 1'b1);
      chk_state("empty w+r", 1, 0, 0, 0, 1, 1);
      chk("empty w+r r_data", int'(FIFO_r_data), 32'h33);

      // Flush at count 9 with a concurrent write.
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'(64 + i), 1'b0);
      chk("pre-clr count", int'(FIFO_count), 9);
      cyc(1'b1, 1'b1, 8'hEE, 1'b0);
      chk_state("clr", 0, 1, 0, 0, 0, 0);

      // Pointer wrap with occupancy held at 3.
      v = 8'h80;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, v, 1'b0);
         q.push_back(v);
         v = v + 8'd1;
      end
      for (int k = 0; k < 40; k++) begin
         c = int'(FIFO_r_data);
         if (k % 8 == 0 || k == 39) chk($sformatf("wrap%0d r_data", k), c, int'(q[0]));
         else if (c != int'(q[0])) chk($sformatf("wrap%0d r_data", k), c, int'(q[0]));
         cyc(1'b0, 1'b1, v, 1'b1);
         void'(q.pop_front());
         q.push_back(v);
         v = v + 8'd1;
         if (k % 10 == 9) chk($sformatf("wrap%0d count", k), int'(FIFO_count), 3);
      end
      while (q.size() > 0) begin
         chk("wrap drain r_data", int'(FIFO_r_data), int'(q[0]));
         cyc(1'b0, 1'b0, 8'h00, 1'b1);
         void'(q.pop_front());
      end
      chk_state("wrap end", 0, 1, 0, 0, 0, 0);

      // Asynchronous reset in the middle of a burst, checked before any edge.
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(i), 1'b0);
      FIFO_w_en   = 1'b1;
      FIFO_w_data = 8'hC3;
      #2;
      glb_rstn = 1'b0;
      #1;
      chk_state("async reset", 0, 1, 0, 0, 0, 0);
      FIFO_w_en = 1'b0;
      @(negedge glb_clk);
      glb_rstn = 1'b1;
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk_state("after reset idle", 0, 1, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
